// File: rtl/l0_loader_if.sv
// Loader-facing bus: controller start/status, SRAM read port and L0 write/read port.
// master = the loader; slave = controller/SRAM/L0 side.
interface l0_loader_if #(
  parameter int row     = 8,
  parameter int bw      = 4,
  parameter int addr_bw = 11
);
  logic                  start;
  logic [addr_bw-1:0]    base_addr;
  logic [addr_bw-1:0]    len;
  logic                  sram_cen;
  logic                  sram_wen;
  logic [addr_bw-1:0]    sram_addr;
  logic [row*bw-1:0]     sram_q;
  logic                  l0_wr;
  logic [row*bw-1:0]     l0_in;
  logic                  l0_full;
  logic                  l0_rd;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, base_addr, len, sram_q, l0_full,
    output sram_cen, sram_wen, sram_addr, l0_wr, l0_in, l0_rd, busy, done
  );

  modport slave (
    output start, base_addr, len, sram_q, l0_full,
    input  sram_cen, sram_wen, sram_addr, l0_wr, l0_in, l0_rd, busy, done
  );
endinterface

// File: rtl/l0_loader.sv
// Streams len SRAM words into L0 (1 word/cycle, SRAM data one cycle after read), then drains L0.
// l0_full stalls read issue; a word already in flight is parked in a one-entry hold register.
module l0_loader #(
  parameter int row     = 8,
  parameter int bw      = 4,
  parameter int addr_bw = 11
) (
  input logic         clk,
  input logic         reset,
  l0_loader_if.master bus
);
  localparam int DW = row * bw;
  localparam logic [addr_bw-1:0] FLUSH_LAST = addr_bw'(row - 2);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, FLUSH, DONE} state_t;

  state_t             state, state_d;
  logic [addr_bw-1:0] base_q, len_q;
  logic [addr_bw-1:0] issued_cnt, written_cnt, cnt;
  logic [DW-1:0]      hold_q;
  logic               hold_vld, inflight;

  logic               issue, wr, rd, done_p, capture;
  logic [DW-1:0]      wr_dat;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issued_cnt  <= '0;
      written_cnt <= '0;
      cnt         <= '0;
      hold_q      <= '0;
      hold_vld    <= 1'b0;
      inflight    <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= (state_d != state) ? '0 : cnt + 1'b1;
      inflight <= issue;
      if (state == IDLE && bus.start) begin
        base_q      <= bus.base_addr;
        len_q       <= bus.len;
        issued_cnt  <= '0;
        written_cnt <= '0;
      end else begin
        issued_cnt  <= issued_cnt + addr_bw'(issue);
        written_cnt <= written_cnt + addr_bw'(wr);
      end
      // Only one word can be in flight when L0 fills, so a single entry suffices.
      if (capture) begin
        hold_q   <= bus.sram_q;
        hold_vld <= 1'b1;
      end else if (hold_vld && wr) begin
        hold_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state;
    issue   = 1'b0;
    wr      = 1'b0;
    wr_dat  = '0;
    rd      = 1'b0;
    done_p  = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_d = (bus.len == '0) ? DONE : LOAD;
      end
      LOAD: begin
        issue = (issued_cnt < len_q) && !hold_vld && !bus.l0_full;
        if (hold_vld) begin
          wr     = !bus.l0_full;
          wr_dat = hold_q;
        end else if (inflight) begin
          wr      = !bus.l0_full;
          wr_dat  = bus.sram_q;
          capture = bus.l0_full;
        end
        if (written_cnt + addr_bw'(wr) == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        rd = 1'b1;
        if (cnt == len_q - 1'b1) state_d = (row > 1) ? FLUSH : DONE;
      end
      FLUSH: begin
        if (cnt == FLUSH_LAST) state_d = DONE;
      end
      DONE: begin
        done_p  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sram_cen  = ~(issue & ~reset);
  assign bus.sram_wen  = 1'b1;
  assign bus.sram_addr = (issue && !reset) ? base_q + issued_cnt : '0;
  assign bus.l0_wr     = wr & ~reset;
  assign bus.l0_in     = reset ? '0 : wr_dat;
  assign bus.l0_rd     = rd & ~reset;
  assign bus.busy      = (state != IDLE) & ~reset;
  assign bus.done      = done_p & ~reset;
endmodule

// File: tb/tb_l0_loader.sv
// Directed bench for l0_loader: per-cycle output traces compared against hand-derived timelines.
module tb_l0_loader;
  localparam int ROW = 8, BW = 4, AW = 11, DW = ROW * BW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l0_loader_if #(.row(ROW), .bw(BW), .addr_bw(AW)) bus ();
  l0_loader #(.row(ROW), .bw(BW), .addr_bw(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return {5'h15, a, 5'h0a, a};
  endfunction

  // SRAM model: data valid the cycle after a read.
  always @(posedge clk) if (!bus.sram_cen) bus.sram_q <= word(bus.sram_addr);

  logic          cen_a [64];
  logic [AW-1:0] addr_a[64];
  logic          wr_a  [64];
  logic [DW-1:0] in_a  [64];
  logic          rd_a  [64];
  logic          busy_a[64];
  logic          done_a[64];

  task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] l);
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = b; bus.len = l;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.base_addr = '1; bus.len = '1;
  endtask

  task automatic run_cycles(input int n, input int full_lo, input int full_hi,
                            input int rst_c, input int st_a, input int st_b);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      bus.l0_full = (c >= full_lo) && (c <= full_hi);
      reset       = (c == rst_c);
      bus.start   = (c == st_a) || (c == st_b);
      if (bus.start) begin bus.base_addr = 11'h3F0; bus.len = 11'd7; end
      #1;
      cen_a[c]  = bus.sram_cen;  addr_a[c] = bus.sram_addr;
      wr_a[c]   = bus.l0_wr;     in_a[c]   = bus.l0_in;
      rd_a[c]   = bus.l0_rd;     busy_a[c] = bus.busy;
      done_a[c] = bus.done;
    end
    bus.l0_full = 1'b0;
    bus.start   = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.start = 1'b1; bus.base_addr = 11'h055; bus.len = 11'd3;
    bus.l0_full = 1'b0; bus.sram_q = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (bus.sram_cen !== 1'b1) begin failures++; $display("FAIL reset_cen got=%b want=1", bus.sram_cen); end
    checks++; if (bus.sram_wen !== 1'b1) begin failures++; $display("FAIL reset_wen got=%b want=1", bus.sram_wen); end
    checks++; if (bus.sram_addr !== '0) begin failures++; $display("FAIL reset_addr got=%h want=0", bus.sram_addr); end
    checks++; if (bus.l0_wr !== 1'b0) begin failures++; $display("FAIL reset_wr got=%b want=0", bus.l0_wr); end
    checks++; if (bus.l0_in !== '0) begin failures++; $display("FAIL reset_in got=%h want=0", bus.l0_in); end
    checks++; if (bus.l0_rd !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b want=0", bus.l0_rd); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.done); end
    bus.start = 1'b0;
    reset = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b want=0", bus.busy); end
    checks++; if (bus.sram_cen !== 1'b1) begin failures++; $display("FAIL idle_cen got=%b want=1", bus.sram_cen); end
  endtask

  task automatic test_basic;
    launch(11'h010, 11'd4);
    run_cycles(20, 0, -1, 0, 0, 0);
    for (int c = 1; c <= 20; c++) begin
      logic ecen, ewr, erd, ebusy, edone;
      ecen = !(c >= 1 && c <= 4); ewr = (c >= 2 && c <= 5); erd = (c >= 6 && c <= 9);
      ebusy = (c <= 17); edone = (c == 17);
      checks++; if (cen_a[c] !== ecen) begin failures++; $display("FAIL basic_cen c=%0d got=%b want=%b", c, cen_a[c], ecen); end
      if (!ecen) begin
        checks++; if (addr_a[c] !== AW'(16 + c - 1)) begin failures++; $display("FAIL basic_addr c=%0d got=%h want=%h", c, addr_a[c], AW'(16 + c - 1)); end
      end
      checks++; if (wr_a[c] !== ewr) begin failures++; $display("FAIL basic_wr c=%0d got=%b want=%b", c, wr_a[c], ewr); end
      if (ewr) begin
        checks++; if (in_a[c] !== word(AW'(16 + c - 2))) begin failures++; $display("FAIL basic_data c=%0d got=%h want=%h", c, in_a[c], word(AW'(16 + c - 2))); end
      end
      checks++; if (rd_a[c] !== erd) begin failures++; $display("FAIL basic_rd c=%0d got=%b want=%b", c, rd_a[c], erd); end
      checks++; if (busy_a[c] !== ebusy) begin failures++; $display("FAIL basic_busy c=%0d got=%b want=%b", c, busy_a[c], ebusy); end
      checks++; if (done_a[c] !== edone) begin failures++; $display("FAIL basic_done c=%0d got=%b want=%b", c, done_a[c], edone); end
    end
  endtask

  task automatic test_full_stall;
    int nw, nd;
    launch(11'h010, 11'd4);
    run_cycles(30, 3, 5, 0, 0, 0);
    for (int c = 3; c <= 5; c++) begin
      checks++; if (cen_a[c] !== 1'b1) begin failures++; $display("FAIL stall_cen c=%0d got=%b want=1", c, cen_a[c]); end
      checks++; if (wr_a[c] !== 1'b0) begin failures++; $display("FAIL stall_wr c=%0d got=%b want=0", c, wr_a[c]); end
    end
    checks++; if (wr_a[6] !== 1'b1 || in_a[6] !== word(11'h011)) begin failures++; $display("FAIL stall_held c=6 got wr=%b data=%h want wr=1 data=%h", wr_a[6], in_a[6], word(11'h011)); end
    nw = 0; nd = 0;
    for (int c = 1; c <= 30; c++) begin
      if (done_a[c]) nd++;
      if (wr_a[c]) begin
        checks++; if (in_a[c] !== word(AW'(16 + nw))) begin failures++; $display("FAIL stall_order c=%0d got=%h want=%h", c, in_a[c], word(AW'(16 + nw))); end
        nw++;
      end
    end
    checks++; if (nw != 4) begin failures++; $display("FAIL stall_count got=%0d want=4", nw); end
    checks++; if (nd != 1) begin failures++; $display("FAIL stall_done_count got=%0d want=1", nd); end
  endtask

  task automatic test_wrap;
    int na;
    logic [AW-1:0] e;
    launch(11'd2046, 11'd4);
    run_cycles(20, 0, -1, 0, 0, 0);
    na = 0;
    for (int c = 1; c <= 20; c++) begin
      if (!cen_a[c]) begin
        e = AW'(2046 + na);
        checks++; if (addr_a[c] !== e) begin failures++; $display("FAIL wrap_addr n=%0d got=%0d want=%0d", na, addr_a[c], e); end
        na++;
      end
    end
    checks++; if (na != 4) begin failures++; $display("FAIL wrap_count got=%0d want=4", na); end
    checks++; if (in_a[4] !== word(11'd0)) begin failures++; $display("FAIL wrap_data c=4 got=%h want=%h", in_a[4], word(11'd0)); end
  endtask

  task automatic test_len_zero;
    launch(11'h123, 11'd0);
    run_cycles(5, 0, -1, 0, 0, 0);
    for (int c = 1; c <= 5; c++) begin
      checks++; if (done_a[c] !== (c == 1)) begin failures++; $display("FAIL zero_done c=%0d got=%b want=%b", c, done_a[c], c == 1); end
      checks++; if (busy_a[c] !== (c == 1)) begin failures++; $display("FAIL zero_busy c=%0d got=%b want=%b", c, busy_a[c], c == 1); end
      checks++; if (cen_a[c] !== 1'b1 || wr_a[c] !== 1'b0 || rd_a[c] !== 1'b0) begin failures++; $display("FAIL zero_activity c=%0d got cen=%b wr=%b rd=%b want 1 0 0", c, cen_a[c], wr_a[c], rd_a[c]); end
    end
  endtask

  task automatic test_reset_abort;
    launch(11'h100, 11'd8);
    run_cycles(15, 0, -1, 3, 0, 0);
    for (int c = 1; c <= 2; c++) begin
      checks++; if (cen_a[c] !== 1'b0 || addr_a[c] !== AW'(256 + c - 1)) begin failures++; $display("FAIL abort_pre c=%0d got cen=%b addr=%h want 0 %h", c, cen_a[c], addr_a[c], AW'(256 + c - 1)); end
    end
    for (int c = 3; c <= 15; c++) begin
      checks++;
      if (cen_a[c] !== 1'b1 || addr_a[c] !== '0 || wr_a[c] !== 1'b0 || in_a[c] !== '0 ||
          rd_a[c] !== 1'b0 || busy_a[c] !== 1'b0 || done_a[c] !== 1'b0) begin
        failures++;
        $display("FAIL abort_idle c=%0d got cen=%b addr=%h wr=%b rd=%b busy=%b done=%b want idle", c, cen_a[c], addr_a[c], wr_a[c], rd_a[c], busy_a[c], done_a[c]);
      end
    end
    launch(11'h200, 11'd2);
    run_cycles(16, 0, -1, 0, 0, 0);
    for (int c = 1; c <= 16; c++) begin
      logic ecen, ewr;
      ecen = !(c <= 2); ewr = (c == 2 || c == 3);
      checks++; if (cen_a[c] !== ecen) begin failures++; $display("FAIL reload_cen c=%0d got=%b want=%b", c, cen_a[c], ecen); end
      if (!ecen) begin
        checks++; if (addr_a[c] !== AW'(512 + c - 1)) begin failures++; $display("FAIL reload_addr c=%0d got=%h want=%h", c, addr_a[c], AW'(512 + c - 1)); end
      end
      checks++; if (wr_a[c] !== ewr) begin failures++; $display("FAIL reload_wr c=%0d got=%b want=%b", c, wr_a[c], ewr); end
      if (ewr) begin
        checks++; if (in_a[c] !== word(AW'(512 + c - 2))) begin failures++; $display("FAIL reload_data c=%0d got=%h want=%h", c, in_a[c], word(AW'(512 + c - 2))); end
      end
      checks++; if (rd_a[c] !== (c == 4 || c == 5)) begin failures++; $display("FAIL reload_rd c=%0d got=%b want=%b", c, rd_a[c], c == 4 || c == 5); end
      checks++; if (done_a[c] !== (c == 13)) begin failures++; $display("FAIL reload_done c=%0d got=%b want=%b", c, done_a[c], c == 13); end
    end
  endtask

  task automatic test_start_while_busy;
    launch(11'h030, 11'd3);
    run_cycles(20, 0, -1, 0, 2, 15);
    for (int c = 1; c <= 20; c++) begin
      logic ecen;
      ecen = !(c <= 3);
      checks++; if (cen_a[c] !== ecen) begin failures++; $display("FAIL busy_start_cen c=%0d got=%b want=%b", c, cen_a[c], ecen); end
      if (!ecen) begin
        checks++; if (addr_a[c] !== AW'(48 + c - 1)) begin failures++; $display("FAIL busy_start_addr c=%0d got=%h want=%h", c, addr_a[c], AW'(48 + c - 1)); end
      end
      checks++; if (done_a[c] !== (c == 15)) begin failures++; $display("FAIL busy_start_done c=%0d got=%b want=%b", c, done_a[c], c == 15); end
      checks++; if (busy_a[c] !== (c <= 15)) begin failures++; $display("FAIL busy_start_busy c=%0d got=%b want=%b", c, busy_a[c], c <= 15); end
    end
    launch(11'h050, 11'd1);
    run_cycles(12, 0, -1, 0, 0, 0);
    checks++; if (cen_a[1] !== 1'b0 || addr_a[1] !== 11'h050) begin failures++; $display("FAIL next_addr got cen=%b addr=%h want 0 050", cen_a[1], addr_a[1]); end
    checks++; if (cen_a[2] !== 1'b1) begin failures++; $display("FAIL next_single_read got=%b want=1", cen_a[2]); end
    checks++; if (wr_a[2] !== 1'b1 || in_a[2] !== word(11'h050)) begin failures++; $display("FAIL next_write got wr=%b data=%h want 1 %h", wr_a[2], in_a[2], word(11'h050)); end
    checks++; if (rd_a[3] !== 1'b1 || rd_a[4] !== 1'b0) begin failures++; $display("FAIL next_rd got c3=%b c4=%b want 1 0", rd_a[3], rd_a[4]); end
    checks++; if (done_a[11] !== 1'b1 || done_a[10] !== 1'b0) begin failures++; $display("FAIL next_done got c10=%b c11=%b want 0 1", done_a[10], done_a[11]); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_full_stall;
    test_wrap;
    test_len_zero;
    test_reset_abort;
    test_start_while_busy;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/l0_loader.md
Name: l0_loader

Overview:
- Feeds the L0 input buffer from activation/weight SRAM: streams `len` consecutive row-packed words (row*bw bits each) from SRAM into L0 while honouring L0's full flag.
- Once all words are written, issues the L0 read strobe so the staggered per-row read wavefront drains into the PE array, then signals completion.
- Sits between the core SRAM and the L0 buffer; started by the top-level controller.

Parameters:
- row, 8, number of L0 rows / PE array rows
- bw, 4, bits per row element
- addr_bw, 11, SRAM address width

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- start  input  1  1-cycle request; sampled only in IDLE
- base_addr  input  addr_bw  first SRAM address; latched on accepted start
- len  input  addr_bw  word count; latched on accepted start
- sram_cen  output  1  SRAM chip enable, active-low
- sram_wen  output  1  SRAM write enable, active-low; tied 1
- sram_addr  output  addr_bw  SRAM read address
- sram_q  input  row*bw  SRAM read data, valid the cycle after the read
- l0_wr  output  1  L0 write strobe
- l0_in  output  row*bw  L0 write data
- l0_full  input  1  L0 full flag, combinational from L0
- l0_rd  output  1  L0 read strobe; L0 staggers it across rows internally
- busy  output  1  high whenever state is not IDLE
- done  output  1  1-cycle completion pulse

Behaviour:
- States: IDLE, LOAD, DRAIN, FLUSH, DONE.
- Reset: state=IDLE; counters, hold register and in-flight flag cleared. All combinational outputs are gated by ~reset. During reset and in IDLE: sram_cen=1, sram_wen=1, sram_addr=0, l0_wr=0, l0_in=0, l0_rd=0, busy=0, done=0.
- Reset in any state aborts the operation. Data already in flight is discarded and nothing further is written.
- IDLE:
  - start=1 latches base_addr and len.
  - len≠0 → LOAD; len=0 → DONE.
  - start outside IDLE is ignored.
- LOAD, read issue:
  - A read issues in cycle t iff issued_cnt<len, hold empty and l0_full=0.
  - On issue: sram_cen=0, sram_addr=base+issued_cnt, modulo 2^addr_bw (address wraps).
  - On issue, the in-flight flag sets for cycle t+1.
- LOAD, write path:
  - If the hold register is valid: l0_wr=~l0_full, l0_in=hold. Hold clears when the write is accepted.
  - Else, if a read is in flight: l0_wr=~l0_full, l0_in=sram_q. If l0_full=1, sram_q is captured into hold at that edge.
  - At most one word is held. Every word is written exactly once, in address order, with no loss or duplication.
  - Throughput is 1 word/cycle when L0 is not full.
- LOAD exit: when written_cnt reaches len at an edge → DRAIN.
- DRAIN: l0_rd=1 for exactly len consecutive cycles → FLUSH.
- FLUSH: row-1 idle cycles let the staggered row reads complete → DONE.
- DONE: done=1 and busy=1 for one cycle → IDLE. A start in the DONE cycle is ignored.
- Counters are addr_bw bits wide; len ≤ 2^addr_bw−1.

Test Plan:
- base=0x010, len=4, l0_full=0, start accepted at edge 0:
  - sram_cen=0 in cycles 1–4 with addrs 0x010–0x013.
  - l0_wr=1 in cycles 2–5 with data equal to the SRAM words in order.
  - l0_rd=1 in cycles 6–9; FLUSH in cycles 10–16.
  - done=1 in cycle 17; busy=1 in cycles 1–17.
- Same stimulus with l0_full=1 during cycles 3–5:
  - The word returned in cycle 3 is held; no reads issue in cycles 3–5.
  - The held word is written in cycle 6 and reads resume.
  - L0 receives all 4 words exactly once, in order.
- base=2046, len=4 → sram_addr sequence 2046, 2047, 0, 1.
- len=0 → done in cycle 1; no sram_cen, l0_wr or l0_rd activity.
- Reset asserted in cycle 3 of a len=8 load:
  - From that edge on, all outputs are at idle values and no further l0_wr occurs.
  - A new start then runs a clean len=2 load.
- A start pulse while busy changes nothing. Only the next start in IDLE launches a load, using that cycle's base_addr and len.
